// File: rtl/fir_pkg.sv
// Shared widths and types for the sample RAM, the reader and the FIR filter.
package fir_pkg;

  localparam int unsigned SAMPLE_A_WIDTH = 16;
  localparam int unsigned SAMPLE_D_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_e;

  typedef logic [SAMPLE_D_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop = pop & ~empty;

  // Pointer and occupancy update; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/ram_sample_reader.sv
// Streams NUM_SAMPLES words out of the sample RAM into the filter's valid/ready input,
// absorbing the RAM read latency through a credit-checked show-ahead FIFO.
module ram_sample_reader
  import fir_pkg::*;
#(
  parameter int unsigned A_WIDTH     = SAMPLE_A_WIDTH,
  parameter int unsigned D_WIDTH     = SAMPLE_D_WIDTH,
  parameter int unsigned NUM_SAMPLES = 65536,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               loop_en,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [A_WIDTH-1:0] ram_addr,
  input  logic [D_WIDTH-1:0] ram_r_data,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(NUM_SAMPLES - 1);

  reader_state_e      state_q, state_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic               ram_cs_q, ram_cs_d;
  logic               inflight_q, inflight_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]   fifo_count, fifo_count_d;

  assign fifo_push = inflight_q & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & m_ready;
  assign fifo_count_d = abort ? '0
                      : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  // ram_cs is registered, so the issue decision for the next cycle is taken here from
  // the values the FIFO count and inflight flag will hold during that issue cycle.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    ram_addr_d = ram_addr_q;
    ram_cs_d   = 1'b0;
    inflight_d = ram_cs_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (ram_cs_q && (ram_addr_q == LAST_ADDR) && !loop_en) state_d = DRAIN;
      DRAIN:   if ((fifo_count_d == '0) && !inflight_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end
    if ((state_d == READ) &&
        ((CNT_W+1)'(fifo_count_d) + (CNT_W+1)'(inflight_d) < (CNT_W+1)'(FIFO_DEPTH))) begin
      ram_cs_d   = 1'b1;
      ram_addr_d = rd_ptr_q;
      rd_ptr_d   = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + A_WIDTH'(1);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      ram_addr_q <= '0;
      ram_cs_q   <= 1'b0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_cs_q   <= ram_cs_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (D_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (ram_r_data),
    .pop       (fifo_pop),
    .flush     (abort),
    .pop_data  (m_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign m_valid  = ~fifo_empty;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_cs   = ram_cs_q;
  assign ram_we   = 1'b0;
  assign ram_addr = ram_addr_q;

endmodule
